uart_tx_arbiter: RTL and testbench

- Round-robin scheduler that shares one uart_tx serializer between NREQ byte producers, e.g. the ALU result path and the debug/echo path.
- Each requester offers one byte with a valid/ready handshake. The arbiter picks a winner, pulses tx_start with the winner's byte, waits for tx_done_tick, then re-arbitrates.
- Sits between the requesters and uart_tx, in the same clock domain.

---
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NREQ byte producers; all outputs registered.
// Define UART_TX_ARB_TIMEOUT_EN to add a tx_done_tick watchdog (sticky o_timeout_err).
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DBIT    = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ*DBIT-1:0]     i_req_data,
  output logic [NREQ-1:0]          o_req_ready,
  output logic                     o_tx_start,
  output logic [DBIT-1:0]          o_tx_din,
  input  logic                     i_tx_done_tick,
  output logic [$clog2(NREQ)-1:0]  o_grant_id,
  output logic                     o_busy,
  output logic                     o_done_tick,
  output logic                     o_timeout_err
);

  localparam int IDW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || DBIT < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t            r_state;
  logic [IDW-1:0]    r_last;
  logic [NREQ-1:0]   r_req_ready;
  logic              r_tx_start;
  logic [DBIT-1:0]   r_tx_din;
  logic [IDW-1:0]    r_grant_id;
  logic              r_busy;
  logic              r_done_tick;
  logic              r_timeout_err;

  logic              w_hi_found;
  logic              w_lo_found;
  logic [IDW-1:0]    w_hi;
  logic [IDW-1:0]    w_lo;
  logic              w_found;
  logic [IDW-1:0]    w_win;
  logic [NREQ-1:0]   w_win_onehot;
  logic [DBIT-1:0]   w_win_data;
  logic              w_done;

  // Rotating priority as two passes: lowest valid index above r_last first,
  // otherwise lowest valid index at or below r_last (wrap-around).
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) begin
        if (IDW'(i) > r_last) begin
          w_hi_found = 1'b1;
          w_hi       = IDW'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo       = IDW'(i);
        end
      end
    end
    w_found = w_hi_found | w_lo_found;
    w_win   = w_hi_found ? w_hi : w_lo;
  end

  always_comb begin
    w_win_onehot = '0;
    w_win_data   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_win_onehot[i] = 1'b1;
        w_win_data      = i_req_data[i*DBIT +: DBIT];
      end
    end
  end

  // A tick coinciding with the start pulse belongs to no frame of ours.
  assign w_done = i_tx_done_tick & ~r_tx_start;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= S_IDLE;
      r_last        <= IDW'(NREQ - 1);
      r_req_ready   <= '0;
      r_tx_start    <= 1'b0;
      r_tx_din      <= '0;
      r_grant_id    <= '0;
      r_busy        <= 1'b0;
      r_done_tick   <= 1'b0;
      r_timeout_err <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      r_tmo_cnt     <= '0;
`endif
    end else begin
      r_req_ready <= '0;
      r_tx_start  <= 1'b0;
      r_done_tick <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state     <= S_WAIT;
            r_req_ready <= w_win_onehot;
            r_tx_start  <= 1'b1;
            r_tx_din    <= w_win_data;
            r_grant_id  <= w_win;
            r_last      <= w_win;
            r_busy      <= 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (w_done) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done_tick <= 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
          end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            // Frame abandoned: byte dropped, pointer already advanced at grant.
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_tx_start  = r_tx_start;
  assign o_tx_din    = r_tx_din;
  assign o_grant_id  = r_grant_id;
  assign o_busy      = r_busy;
  assign o_done_tick = r_done_tick;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign o_timeout_err = r_timeout_err;
`else
  assign o_timeout_err = 1'b0 & r_timeout_err;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=4, DBIT=8, TIMEOUT=50).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_din;
  logic        tx_done_tick;
  logic [1:0]  grant_id;
  logic        busy;
  logic        done_tick;
  logic        timeout_err;
  logic [17:0] outs;
  logic [17:0] any_out;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_arbiter #(.NREQ(4), .DBIT(8), .TIMEOUT(50)) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_req_valid    (req_valid),
    .i_req_data     (req_data),
    .o_req_ready    (req_ready),
    .o_tx_start     (tx_start),
    .o_tx_din       (tx_din),
    .i_tx_done_tick (tx_done_tick),
    .o_grant_id     (grant_id),
    .o_busy         (busy),
    .o_done_tick    (done_tick),
    .o_timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  assign outs = {req_ready, tx_start, tx_din, grant_id, busy, done_tick, timeout_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    tx_done_tick = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", 32'(outs), 32'h0);

    // Quiet bus after reset
    rst_n   = 1'b1;
    any_out = '0;
    repeat (100) begin
      tick();
      any_out = any_out | outs;
    end
    chk("idle_100_cycles", 32'(any_out), 32'h0);

    // Single requester 2
    req_data[23:16] = 8'hA5;
    req_valid       = 4'b0100;
    tick();
    chk("single_tx_start", 32'(tx_start), 32'h1);
    chk("single_req_ready", 32'(req_ready), 32'h4);
    chk("single_tx_din", 32'(tx_din), 32'hA5);
    chk("single_grant_id", 32'(grant_id), 32'h2);
    chk("single_busy", 32'(busy), 32'h1);
    req_valid    = 4'b0000;
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    chk("start_pulse_cleared", 32'(tx_start), 32'h0);
    chk("ready_pulse_cleared", 32'(req_ready), 32'h0);
    chk("tick_with_start_ignored_busy", 32'(busy), 32'h1);
    chk("tick_with_start_ignored_done", 32'(done_tick), 32'h0);
    repeat (5) tick();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    chk("single_done_tick", 32'(done_tick), 32'h1);
    chk("single_busy_cleared", 32'(busy), 32'h0);
    tick();
    chk("done_tick_one_cycle", 32'(done_tick), 32'h0);
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    chk("idle_tick_ignored_done", 32'(done_tick), 32'h0);
    chk("idle_tick_ignored_busy", 32'(busy), 32'h0);

    // Round robin over four continuously valid requesters
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    req_data  = 32'h13121110;
    req_valid = 4'b1111;
    tick();
    chk("rr_first_start", 32'(tx_start), 32'h1);
    for (int f = 0; f < 5; f++) begin
      chk("rr_tx_din", 32'(tx_din), 32'h10 + 32'(f % 4));
      chk("rr_grant_id", 32'(grant_id), 32'(f % 4));
      chk("rr_req_ready", 32'(req_ready), 32'h1 << (f % 4));
      for (int c = 1; c < 160; c++) begin
        tick();
        if (f == 1 && c == 5) req_data[15:8] = 8'hFF;
      end
      if (f == 1) chk("din_held_after_data_change", 32'(tx_din), 32'h11);
      chk("rr_busy_in_frame", 32'(busy), 32'h1);
      tx_done_tick = 1'b1;
      tick();
      tx_done_tick = 1'b0;
      chk("rr_done_tick", 32'(done_tick), 32'h1);
      if (f == 1) req_data[15:8] = 8'h11;
      if (f < 4) begin
        tick();
        chk("rr_one_idle_gap_start", 32'(tx_start), 32'h1);
      end
    end

    // Asynchronous reset in the middle of a frame
    tick();
    chk("pre_reset_grant", 32'(grant_id), 32'h1);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(outs), 32'h0);
    req_valid = 4'b1001;
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_reset_grant_0", 32'(grant_id), 32'h0);
    chk("post_reset_ready_0", 32'(req_ready), 32'h1);
    chk("post_reset_din_0", 32'(tx_din), 32'h10);
    req_valid = 4'b0000;
    rst_n     = 1'b0;
    tick();
    req_valid = 4'b1000;
    rst_n     = 1'b1;
    tick();
    chk("post_reset_grant_3", 32'(grant_id), 32'h3);
    chk("post_reset_ready_3", 32'(req_ready), 32'h8);
    chk("post_reset_din_3", 32'(tx_din), 32'h13);
    req_valid = 4'b0000;

`ifdef UART_TX_ARB_TIMEOUT_EN
    any_out = '0;
    repeat (49) begin
      tick();
      any_out[0] = any_out[0] | done_tick;
    end
    chk("tmo_busy_before_limit", 32'(busy), 32'h1);
    chk("tmo_err_before_limit", 32'(timeout_err), 32'h0);
    tick();
    any_out[0] = any_out[0] | done_tick;
    chk("tmo_busy_cleared", 32'(busy), 32'h0);
    chk("tmo_err_set", 32'(timeout_err), 32'h1);
    chk("tmo_no_done_tick", 32'(any_out[0]), 32'h0);
    repeat (3) tick();
    chk("tmo_err_sticky", 32'(timeout_err), 32'h1);
`else
    repeat (60) tick();
    chk("no_tmo_busy_held", 32'(busy), 32'h1);
    chk("no_tmo_err_zero", 32'(timeout_err), 32'h0);
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    chk("no_tmo_done_tick", 32'(done_tick), 32'h1);
    chk("no_tmo_busy_cleared", 32'(busy), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
